// File: rtl/reg_sel_pkg.sv
// Shared constants, state encoding and bit helpers for the register-select encoder.
package reg_sel_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot16(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt16(input logic [N-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin pick of the first set request at or after start (mod 16).
// REG_SEL_ENC_FIXED_PRIO_EN forces start to 0, giving lowest-index priority.
module rr_pick16
    import reg_sel_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] start_eff;
    logic [N-1:0]     rotated;
    logic [IDX_W-1:0] offset;

`ifdef REG_SEL_ENC_FIXED_PRIO_EN
    logic unused_start;
    assign unused_start = ^start;
    assign start_eff    = IDX_W'(0);
`else
    assign start_eff = start;
`endif

    // Rotate so that bit 'start' lands at position 0.
    assign rotated = (req >> start_eff) | (req << (IDX_W'(N - 1) - start_eff + 1'b1));

    // Lowest set bit of the rotated vector.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
    end

    assign idx = IDX_W'(offset + start_eff);

endmodule

// File: rtl/reg_sel_encoder.sv
// Encodes pending register-request lines into one 4-bit index per valid/ready transfer.
// Round-robin by default; REG_SEL_ENC_FIXED_PRIO_EN selects fixed lowest-index priority.
module reg_sel_encoder
    import reg_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_in,
    input  logic             req_load,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0] pend_cnt_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] ptr_d;
    logic             acc;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign acc       = valid_q & out_ready;
    assign pending_d = (pending_q & ~(acc ? onehot16(idx_q) : '0))
                     | (req_load ? req_in : '0);

`ifdef REG_SEL_ENC_FIXED_PRIO_EN
    assign ptr_d = IDX_W'(0);
`else
    logic [IDX_W-1:0] ptr_q;

    assign ptr_d = acc ? IDX_W'(idx_q + 1'b1) : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    rr_pick16 u_pick (
        .req   (pending_d),
        .start (ptr_d),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-offer selection; out_idx only moves when idle or on accept.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (acc) begin
                    if (pick_found) begin
                        idx_d = pick_idx;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            pend_cnt_q <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_cnt_q <= popcnt16(pending_d);
            idx_q      <= idx_d;
            valid_q    <= valid_d;
        end
    end

    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign pend_cnt  = pend_cnt_q;
    assign busy      = valid_q | (|pending_q);

endmodule

// File: tb/tb_reg_sel_encoder.sv
// Scoreboard bench for reg_sel_encoder: expected indices queued at stimulus, checked on accept.
module tb_reg_sel_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_in;
    logic        req_load;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pending;
    logic [4:0]  pend_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    reg_sel_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .req_load  (req_load),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .pend_cnt  (pend_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        exp_q.push_back(4'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_load  = 1'b0;
        req_in    = '0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Scoreboard: every accepted transfer must match the next expected index.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_q", 32'(exp_q.size()), 1);
            end else begin
                chk("out_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_in    = '0;
        req_load  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_idx", 32'(out_idx), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_cnt", 32'(pend_cnt), 0);
        chk("rst_busy", 32'(busy), 0);

        // Reset mid-offer
        req_in   = 16'h00F0;
        req_load = 1'b1;
        step();
        req_load = 1'b0;
        chk("mid_valid", 32'(out_valid), 1);
        chk("mid_idx", 32'(out_idx), 4);
        chk("mid_pending", 32'(pending), 32'h00F0);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_pending", 32'(pending), 0);
        chk("arst_cnt", 32'(pend_cnt), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // Empty load is a no-op
        req_in   = '0;
        req_load = 1'b1;
        out_ready = 1'b1;
        step();
        req_load = 1'b0;
        chk("noop_busy", 32'(busy), 0);
        chk("noop_valid", 32'(out_valid), 0);

        // Single load, back-to-back drain
        do_reset();
        push(0); push(5); push(10); push(15);
        out_ready = 1'b1;
        req_in    = 16'h8421;
        req_load  = 1'b1;
        step();
        req_load = 1'b0;
        for (int c = 4; c >= 1; c--) begin
            chk("drain_cnt", 32'(pend_cnt), 32'(c));
            step();
        end
        chk("drain_cnt_end", 32'(pend_cnt), 0);
        chk("drain_valid_end", 32'(out_valid), 0);
        wait_drain("drain");

        // Backpressure with a load during the stall
        do_reset();
        req_in   = 16'h0006;
        req_load = 1'b1;
        step();
        req_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_idx", 32'(out_idx), 1);
            if (i == 1) begin
                req_in   = 16'h0001;
                req_load = 1'b1;
            end
            step();
            req_load = 1'b0;
        end
        chk("bp_pending", 32'(pending), 32'h0007);
        chk("bp_cnt", 32'(pend_cnt), 3);
`ifdef REG_SEL_ENC_FIXED_PRIO_EN
        push(1); push(0); push(2);
`else
        push(1); push(2); push(0);
`endif
        out_ready = 1'b1;
        wait_drain("bp");

        // Round-robin wrap with all requests held asserted
        do_reset();
        for (int i = 0; i < 20; i++) begin
`ifdef REG_SEL_ENC_FIXED_PRIO_EN
            push(0);
`else
            push(i % 16);
`endif
        end
        req_in    = 16'hFFFF;
        req_load  = 1'b1;
        out_ready = 1'b1;
        repeat (21) step();
        out_ready = 1'b0;
        req_load  = 1'b0;
        chk("wrap_queue_left", 32'(exp_q.size()), 0);
        do_reset();

        // Accept and re-request the same index in one cycle
`ifdef REG_SEL_ENC_FIXED_PRIO_EN
        push(0); push(3); push(3); push(4);
`else
        push(0); push(3); push(4); push(3);
`endif
        out_ready = 1'b1;
        req_in    = 16'h0019;
        req_load  = 1'b1;
        step();
        req_load = 1'b0;
        step();
        chk("rearm_offer", 32'(out_idx), 3);
        req_in   = 16'h0008;
        req_load = 1'b1;
        step();
        req_load = 1'b0;
        chk("rearm_bit3", 32'(pending[3]), 1);
        chk("rearm_pending", 32'(pending), 32'h0018);
        wait_drain("rearm");

        // Accept idx 0 from 0x8001 while reloading bit 0
        do_reset();
        req_in   = 16'h8001;
        req_load = 1'b1;
        step();
        req_load = 1'b0;
        chk("prio_first", 32'(out_idx), 0);
`ifdef REG_SEL_ENC_FIXED_PRIO_EN
        push(0); push(0); push(15);
`else
        push(0); push(15); push(0);
`endif
        out_ready = 1'b1;
        req_in    = 16'h0001;
        req_load  = 1'b1;
        step();
        req_load = 1'b0;
        chk("prio_pending", 32'(pending), 32'h8001);
        wait_drain("prio");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
